// File: rtl/seg_pkg.sv
// seg_pkg -- shared constants for the 7-segment multiplex driver.
// Segment bytes are active-low {dp,g,f,e,d,c,b,a}. A 0 bit lights a segment.
package seg_pkg;

    // Index n holds the pattern for decimal digit n, with dp off.
    localparam logic [9:0][7:0] SEG_DIGIT = {
        8'h90,  // 9
        8'h80,  // 8
        8'hF8,  // 7
        8'h82,  // 6
        8'h92,  // 5
        8'h99,  // 4
        8'hB0,  // 3
        8'hA4,  // 2
        8'hF9,  // 1
        8'hC0   // 0
    };

    localparam logic [7:0] SEG_DASH  = 8'hBF;  // only g lit
    localparam logic [7:0] SEG_BLANK = 8'hFF;  // all segments dark

    // Polarity: digit enables and the colon are active-low.
    localparam logic DIG_OFF = 1'b1;
    localparam logic COL_ON  = 1'b0;
    localparam logic COL_OFF = 1'b1;

endpackage

// File: rtl/seg_mux_driver_if.sv
// seg_mux_driver_if -- load/display bundle for seg_mux_driver.
//   digits_in   : BCD nibbles, nibble i drives digit i (digit 0 rightmost)
//   load        : one-cycle strobe that captures digits_in/colon_in
//   colon_in    : colon request, 1 = lit
//   blink_mask  : per-digit blink enable, used live
//   IO_SSEG     : active-low segments {dp,g..a}
//   IO_SSEGD    : active-low one-hot digit enables
//   IO_SSEG_COL : active-low colon
//   frame_done  : one-cycle pulse when the scan wraps to digit 0
interface seg_mux_driver_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] digits_in;
    logic                    load;
    logic                    colon_in;
    logic [NUM_DIGITS-1:0]   blink_mask;
    logic [7:0]              IO_SSEG;
    logic [NUM_DIGITS-1:0]   IO_SSEGD;
    logic                    IO_SSEG_COL;
    logic                    frame_done;

    modport master (
        output digits_in, load, colon_in, blink_mask,
        input  IO_SSEG, IO_SSEGD, IO_SSEG_COL, frame_done
    );

    modport slave (
        input  digits_in, load, colon_in, blink_mask,
        output IO_SSEG, IO_SSEGD, IO_SSEG_COL, frame_done
    );
endinterface

// File: rtl/seg_mux_driver_decode.sv
// seg7_decode -- combinational BCD nibble to active-low segment byte.
//   i_nibble : 4-bit value; 0-9 decode to digits, 10-15 to a dash
//   o_seg    : active-low {dp,g..a}
module seg7_decode
    import seg_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [7:0] o_seg
);
    always_comb begin
        o_seg = SEG_DASH;
        case (i_nibble)
            4'd0: o_seg = SEG_DIGIT[0];
            4'd1: o_seg = SEG_DIGIT[1];
            4'd2: o_seg = SEG_DIGIT[2];
            4'd3: o_seg = SEG_DIGIT[3];
            4'd4: o_seg = SEG_DIGIT[4];
            4'd5: o_seg = SEG_DIGIT[5];
            4'd6: o_seg = SEG_DIGIT[6];
            4'd7: o_seg = SEG_DIGIT[7];
            4'd8: o_seg = SEG_DIGIT[8];
            4'd9: o_seg = SEG_DIGIT[9];
            default: o_seg = SEG_DASH;
        endcase
    end
endmodule

// File: rtl/seg_mux_driver.sv
// seg_mux_driver -- time-multiplexed 7-segment display driver.
// Ports:
//   M_CLOCK : clock, all state on the rising edge
//   M_RESET : synchronous active-high reset
//   bus     : seg_mux_driver_if.slave (data/load in, segment drive out)
// Parameters: NUM_DIGITS (1..8), REFRESH_DIV (>=2) cycles per digit slot,
//             BLINK_DIV (>=2) cycles per blink half-period.
// Build option: define SEG_LEADING_BLANK_EN to blank leading zero digits.
// New data is staged in a pending register and only swapped into the
// displayed (active) register at a scan wrap, so a frame never tears.
module seg_mux_driver
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int BLINK_DIV   = 25000000
) (
    input  logic              M_CLOCK,
    input  logic              M_RESET,
    seg_mux_driver_if.slave   bus
);
    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int SLOT_W = $clog2(REFRESH_DIV);
    localparam int BLK_W  = $clog2(BLINK_DIV);

    if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_num_digits
        $error("seg_mux_driver: NUM_DIGITS must be 1..8");
    end
    if (REFRESH_DIV < 2) begin : g_bad_refresh_div
        $error("seg_mux_driver: REFRESH_DIV must be >= 2");
    end
    if (BLINK_DIV < 2) begin : g_bad_blink_div
        $error("seg_mux_driver: BLINK_DIV must be >= 2");
    end

    logic [SLOT_W-1:0]           r_slot_cnt;
    logic [IDX_W-1:0]            r_idx;
    logic [BLK_W-1:0]            r_blink_cnt;
    logic                        r_blink_phase;
    logic [NUM_DIGITS-1:0][3:0]  r_act_dig;
    logic                        r_act_col;
    logic [NUM_DIGITS-1:0][3:0]  r_pend_dig;
    logic                        r_pend_col;
    logic                        r_pend_vld;
    logic [7:0]                  r_sseg;
    logic [NUM_DIGITS-1:0]       r_ssegd;
    logic                        r_col;
    logic                        r_frame_done;

    logic [NUM_DIGITS-1:0][3:0]  w_din;
    logic                        w_slot_end;
    logic                        w_wrap;
    logic [3:0]                  w_nib;
    logic [7:0]                  w_dec;
    logic [7:0]                  w_seg_nxt;
    logic [NUM_DIGITS-1:0]       w_onehot;

    assign w_din      = bus.digits_in;
    assign w_slot_end = (r_slot_cnt == SLOT_W'(REFRESH_DIV - 1));
    assign w_wrap     = w_slot_end && (r_idx == IDX_W'(NUM_DIGITS - 1));
    assign w_nib      = r_act_dig[r_idx];
    assign w_onehot   = NUM_DIGITS'(1) << r_idx;

    seg7_decode u_dec (
        .i_nibble (w_nib),
        .o_seg    (w_dec)
    );

`ifdef SEG_LEADING_BLANK_EN
    // A digit blanks when it and every digit above it are zero; digit 0
    // is never considered so a value of 0 still shows a single zero.
    logic [NUM_DIGITS-1:0] w_lead_blank;
    logic                  w_run;
    always_comb begin
        w_lead_blank = '0;
        w_run        = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            w_run           = w_run && (r_act_dig[i] == 4'd0);
            w_lead_blank[i] = w_run;
        end
    end
`endif

    // Blink only darkens segments; the enable keeps its normal timing.
    always_comb begin
        w_seg_nxt = w_dec;
`ifdef SEG_LEADING_BLANK_EN
        if (w_lead_blank[r_idx]) w_seg_nxt = SEG_BLANK;
`endif
        if (r_blink_phase && bus.blink_mask[r_idx]) w_seg_nxt = SEG_BLANK;
    end

    always_ff @(posedge M_CLOCK) begin
        if (M_RESET) begin
            r_slot_cnt    <= '0;
            r_idx         <= '0;
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
            r_act_dig     <= '0;
            r_act_col     <= 1'b0;
            r_pend_dig    <= '0;
            r_pend_col    <= 1'b0;
            r_pend_vld    <= 1'b0;
            r_sseg        <= SEG_BLANK;
            r_ssegd       <= {NUM_DIGITS{DIG_OFF}};
            r_col         <= COL_OFF;
            r_frame_done  <= 1'b0;
        end else begin
            if (w_slot_end) begin
                r_slot_cnt <= '0;
                r_idx      <= w_wrap ? '0 : r_idx + IDX_W'(1);
            end else begin
                r_slot_cnt <= r_slot_cnt + SLOT_W'(1);
            end
            r_frame_done <= w_wrap;

            if (r_blink_cnt == BLK_W'(BLINK_DIV - 1)) begin
                r_blink_cnt   <= '0;
                r_blink_phase <= ~r_blink_phase;
            end else begin
                r_blink_cnt <= r_blink_cnt + BLK_W'(1);
            end

            // A load landing on the wrap cycle bypasses pending entirely.
            if (w_wrap) begin
                if (bus.load) begin
                    r_act_dig <= w_din;
                    r_act_col <= bus.colon_in;
                end else if (r_pend_vld) begin
                    r_act_dig <= r_pend_dig;
                    r_act_col <= r_pend_col;
                end
                r_pend_vld <= 1'b0;
            end else if (bus.load) begin
                r_pend_dig <= w_din;
                r_pend_col <= bus.colon_in;
                r_pend_vld <= 1'b1;
            end

            // Slot cycle 0 keeps every digit off to hide segment ghosting.
            r_sseg  <= w_seg_nxt;
            r_ssegd <= (r_slot_cnt == '0) ? {NUM_DIGITS{DIG_OFF}} : ~w_onehot;
            r_col   <= r_act_col ? COL_ON : COL_OFF;
        end
    end

    assign bus.IO_SSEG     = r_sseg;
    assign bus.IO_SSEGD    = r_ssegd;
    assign bus.IO_SSEG_COL = r_col;
    assign bus.frame_done  = r_frame_done;

endmodule

// File: tb/tb_seg_mux_driver.sv
// tb_seg_mux_driver -- directed bench for seg_mux_driver with
// NUM_DIGITS=4, REFRESH_DIV=4, BLINK_DIV=32 (16-cycle frames).
module tb_seg_mux_driver;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc;
    int   n_chk  = 0;
    int   n_pass = 0;
    int   seq_err;
    logic [7:0] seen [4];

    always #5 clk = ~clk;

    // Cycles since reset release; a frame starts every 16 cycles.
    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    seg_mux_driver_if #(.NUM_DIGITS(4)) bus ();

    seg_mux_driver #(
        .NUM_DIGITS  (4),
        .REFRESH_DIV (4),
        .BLINK_DIV   (32)
    ) dut (
        .M_CLOCK (clk),
        .M_RESET (rst),
        .bus     (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic pulse_load(input logic [15:0] d, input logic c);
        bus.digits_in = d;
        bus.colon_in  = c;
        bus.load      = 1'b1;
        @(negedge clk);
        bus.load      = 1'b0;
    endtask

    // Returns at the negedge where frame_done is high.
    task automatic wait_fd();
        for (int i = 0; i < 40; i++) begin
            if (bus.frame_done === 1'b1) return;
            @(negedge clk);
        end
        chk("frame_done_timeout", 32'd0, 32'd1);
    endtask

    // Samples n cycles; pos counts from the frame start. Position p shows
    // the state of frame cycle p: gap at p%4==0, else digit p/4 low.
    task automatic scan(input int n, input int pos0);
        logic [3:0] exp_en;
        int pos;
        for (int d = 0; d < 4; d++) seen[d] = 8'h00;
        seq_err = 0;
        for (int j = 0; j < n; j++) begin
            @(negedge clk);
            pos    = pos0 + j;
            exp_en = (pos % 4 == 0) ? 4'hF : ~(4'b0001 << (pos / 4));
            if (bus.IO_SSEGD !== exp_en) seq_err++;
            if (pos % 4 != 0) seen[pos / 4] = bus.IO_SSEG;
        end
    endtask

    task automatic chk_frame(input string tag, input logic [7:0] e3, input logic [7:0] e2,
                             input logic [7:0] e1, input logic [7:0] e0);
        chk({tag, "_d3"}, seen[3], e3);
        chk({tag, "_d2"}, seen[2], e2);
        chk({tag, "_d1"}, seen[1], e1);
        chk({tag, "_d0"}, seen[0], e0);
    endtask

    initial begin
        logic [7:0] exp_d1;
        bus.digits_in  = '0;
        bus.load       = 1'b0;
        bus.colon_in   = 1'b0;
        bus.blink_mask = '0;

        // Reset held for 3 cycles
        repeat (3) @(negedge clk);
        chk("rst_sseg", bus.IO_SSEG, 8'hFF);
        chk("rst_ssegd", bus.IO_SSEGD, 4'hF);
        chk("rst_col", bus.IO_SSEG_COL, 1'b1);
        chk("rst_fd", bus.frame_done, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        chk("rel1_ssegd", bus.IO_SSEGD, 4'hF);
        @(negedge clk);
        chk("rel2_ssegd", bus.IO_SSEGD, 4'hE);
        chk("rel2_sseg", bus.IO_SSEG, 8'hC0);

        // 1234 with colon, shown from the next frame
        pulse_load(16'h1234, 1'b1);
        wait_fd();
        chk("fd_cyc", cyc, 16);
        @(negedge clk);
        chk("fd_pulse_len", bus.frame_done, 1'b0);
        scan(15, 1);
        chk_frame("f1234", 8'hF9, 8'hA4, 8'hB0, 8'h99);
        chk("f1234_seq", seq_err, 0);
        chk("f1234_col", bus.IO_SSEG_COL, 1'b0);

        // Mid-frame load waits for the wrap
        wait_fd();
        pulse_load(16'h5678, 1'b1);
        scan(15, 1);
        chk_frame("old1234", 8'hF9, 8'hA4, 8'hB0, 8'h99);
        chk("wrap_fd", bus.frame_done, 1'b1);
        scan(16, 0);
        chk_frame("f5678", 8'h92, 8'h82, 8'hF8, 8'h80);

        // Pending 9999, then a load on the wrap cycle wins and clears pending
        wait_fd();
        pulse_load(16'h9999, 1'b0);
        repeat (14) @(negedge clk);
        pulse_load(16'h4321, 1'b0);
        chk("coinc_fd", bus.frame_done, 1'b1);
        scan(16, 0);
        chk_frame("f4321", 8'h99, 8'hB0, 8'hA4, 8'hF9);
        chk("f4321_col", bus.IO_SSEG_COL, 1'b1);
        scan(16, 0);
        chk_frame("f4321_hold", 8'h99, 8'hB0, 8'hA4, 8'hF9);

        // Second load overwrites the first; nibble C decodes to a dash
        pulse_load(16'h1111, 1'b0);
        pulse_load(16'hCCCC, 1'b0);
        wait_fd();
        scan(16, 0);
        chk_frame("fdash", 8'hBF, 8'hBF, 8'hBF, 8'hBF);
        chk("fdash_seq", seq_err, 0);

        // Blink digit 1; phase is set by the frame's start cycle
        bus.blink_mask = 4'b0010;
        pulse_load(16'h1234, 1'b1);
        wait_fd();
        for (int f = 0; f < 4; f++) begin
            exp_d1 = (((cyc / 32) % 2) == 1) ? 8'hFF : 8'hB0;
            scan(16, 0);
            chk("blink_d1", seen[1], exp_d1);
            chk("blink_d0", seen[0], 8'h99);
            chk("blink_d3", seen[3], 8'hF9);
            chk("blink_col", bus.IO_SSEG_COL, 1'b0);
            chk("blink_seq", seq_err, 0);
        end
        bus.blink_mask = 4'b0000;

        // Leading-zero handling
        pulse_load(16'h0070, 1'b0);
        wait_fd();
        scan(16, 0);
`ifdef SEG_LEADING_BLANK_EN
        chk_frame("f0070", 8'hFF, 8'hFF, 8'hF8, 8'hC0);
`else
        chk_frame("f0070", 8'hC0, 8'hC0, 8'hF8, 8'hC0);
`endif
        pulse_load(16'h0000, 1'b0);
        wait_fd();
        scan(16, 0);
`ifdef SEG_LEADING_BLANK_EN
        chk_frame("f0000", 8'hFF, 8'hFF, 8'hFF, 8'hC0);
`else
        chk_frame("f0000", 8'hC0, 8'hC0, 8'hC0, 8'hC0);
`endif

        // Reset mid-frame drops both active and pending data
        pulse_load(16'h9999, 1'b1);
        wait_fd();
        pulse_load(16'h8888, 1'b1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("mrst_sseg", bus.IO_SSEG, 8'hFF);
        chk("mrst_ssegd", bus.IO_SSEGD, 4'hF);
        chk("mrst_col", bus.IO_SSEG_COL, 1'b1);
        chk("mrst_fd", bus.frame_done, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        chk("mrel1_ssegd", bus.IO_SSEGD, 4'hF);
        @(negedge clk);
        chk("mrel2_ssegd", bus.IO_SSEGD, 4'hE);
        chk("mrel2_sseg", bus.IO_SSEG, 8'hC0);
        chk("mrel2_col", bus.IO_SSEG_COL, 1'b1);
        wait_fd();
        chk("mrst_fd_cyc", cyc, 16);
        scan(16, 0);
        chk_frame("fcleared", 8'hC0, 8'hC0, 8'hC0, 8'hC0);
        chk("fcleared_seq", seq_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/seg_mux_driver.md
SEG_MUX_DRIVER -- requirements
Module: seg_mux_driver

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, number of multiplexed digits (legal range 1..8).
REQ-002 SHALL have parameter REFRESH_DIV, default 50000, clock cycles per digit slot (minimum 2).
REQ-003 SHALL have parameter BLINK_DIV, default 25000000, clock cycles per blink half-period (minimum 2).
REQ-004 SHALL have one clock and a synchronous, active-high reset.
REQ-005 M_CLOCK  input  1  sole clock; all state updates on rising edge.
REQ-006 M_RESET  input  1  synchronous active-high reset.
REQ-007 digits_in  input  4*NUM_DIGITS  BCD nibbles; nibble i drives digit i; digit 0 is rightmost.
REQ-008 load  input  1  single-cycle strobe that captures digits_in and colon_in.
REQ-009 colon_in  input  1  colon request, 1 = lit.
REQ-010 blink_mask  input  NUM_DIGITS  1 = digit blinks; sampled live, not shadowed.
REQ-011 IO_SSEG  output  8  active-low segments, {dp,g..a}.
REQ-012 IO_SSEGD  output  NUM_DIGITS  active-low one-hot digit enables.
REQ-013 IO_SSEG_COL  output  1  active-low colon.
REQ-014 frame_done  output  1  one-cycle pulse at each scan wrap.

Function
REQ-015 Slot counter SHALL count 0..REFRESH_DIV-1; at terminal count it SHALL reset to 0 and advance digit index, wrapping NUM_DIGITS-1 -> 0.
REQ-016 frame_done SHALL pulse in the cycle the index wraps to 0.
REQ-017 load SHALL write digits_in and colon_in into a pending register and set pending_valid; a later load before the boundary SHALL overwrite it.
REQ-018 At a frame boundary with pending_valid set, pending SHALL copy to the active register and pending_valid SHALL clear.
REQ-019 If load coincides with a frame boundary, that cycle's digits_in and colon_in SHALL go directly to the active register and pending_valid SHALL clear.
REQ-020 Outputs SHALL be registered: IO_SSEG and IO_SSEGD SHALL reflect a new index one cycle after the index changes.
REQ-021 In the first cycle of every slot, IO_SSEGD SHALL be all ones (anti-ghost gap); in the remaining cycles, only the indexed bit SHALL be 0.
REQ-022 Nibble decode: 0-9 SHALL give the standard digit patterns with dp off; 10-15 SHALL give dash 8'b10111111.
REQ-023 Blink counter SHALL toggle blink_phase every BLINK_DIV cycles; while blink_phase=1, the segments of a digit whose blink_mask bit is set SHALL be 8'hFF, and its enable SHALL still be driven.
REQ-024 IO_SSEG_COL SHALL be the inverse of the active colon bit and SHALL be independent of blink.

Reset
REQ-025 While reset is held, outputs SHALL be: IO_SSEG=8'hFF, IO_SSEGD all ones, IO_SSEG_COL=1, frame_done=0.
REQ-026 Reset SHALL clear slot counter, index, blink counter, blink_phase, active digits, active colon, pending register and pending_valid.
REQ-027 Reset asserted mid-frame SHALL discard pending data; scanning SHALL restart at digit 0 with slot count 0 in the first cycle after release.

Configuration
REQ-028 Macro SEG_LEADING_BLANK_EN SHALL control leading-zero blanking.
REQ-029 When SEG_LEADING_BLANK_EN is defined, zero digits above the most significant nonzero digit SHALL show 8'hFF, and digit 0 SHALL never blank.
REQ-030 When SEG_LEADING_BLANK_EN is undefined, all digits SHALL display as decoded, and no blanking logic SHALL be present.

Structure
REQ-031 Shared package seg_pkg SHALL hold the ten digit patterns, DASH and BLANK constants, and the polarity constants.
REQ-032 Combinational nibble-to-segment decode SHALL be the sub-module seg7_decode.
REQ-033 Parameters outside their legal range SHALL cause an elaboration error.

Verification (NUM_DIGITS=4, REFRESH_DIV=4, BLINK_DIV=32)
REQ-034 Scenario 1: reset held for 3 cycles -> IO_SSEG=8'hFF, IO_SSEGD=4'hF, IO_SSEG_COL=1, frame_done=0; after release, digit 0 is enabled within 2 cycles.
REQ-035 Scenario 2: load with 16'h1234 and colon 1 -> after the next frame_done, digit0=8'b10011001, digit3=8'b11111001, IO_SSEG_COL=0.
REQ-036 Scenario 3: load 16'h5678 mid-frame -> old data persists until frame_done; load coinciding with wrap -> new data is visible in the next frame.
REQ-037 Scenario 4: nibble 4'hC -> segments 8'b10111111; every slot shows 1 cycle of IO_SSEGD=4'hF, then 3 cycles of one-hot low.
REQ-038 Scenario 5: blink_mask=4'b0010 -> digit1 segments alternate between decoded value and 8'hFF every 32 cycles; the other digits are unaffected.
REQ-039 Scenario 6: SEG_LEADING_BLANK_EN defined with 16'h0070 -> digits 3 and 2 blank, digit1=SEVEN, digit0=ZERO; input 16'h0000 -> only digit0 lit.
